// File: rtl/fp_prep_arbiter.sv
// fp_prep_arbiter
//   Two requesters share one FP32 add/sub operand-preparation datapath.
//   Requests are granted round-robin, one operand pair at a time. For each
//   pair the block decodes both operands and orders them by magnitude. It
//   then builds the 24-bit mantissas and the clamped alignment shift,
//   classifies special values, and hands one prepared result downstream.
//
//   Build option: define FP_PREP_FTZ_EN to flush denormal inputs to signed
//   zero at decode. When the macro is undefined, denormals keep hidden bit 0.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   in_valid[1:0]        per-requester request
//   in_ready[1:0]        per-requester accept (combinational)
//   in_a0/in_b0          requester 0 operands
//   in_a1/in_b1          requester 1 operands
//   in_sub[1:0]          per-requester op (1 = a-b)
//   out_valid/out_ready  result handshake to the adder
//   out_id               requester that owns the result
//   out_sign_big/small   signs of the ordered operands (b sign inverted on sub)
//   out_exp_big          effective exponent of the larger operand
//   out_mant_big/small   {hidden,frac} of the ordered operands
//   out_diff             min(exp_big - exp_small, DIFF_MAX)
//   out_swap             1 when |b| > |a|
//   out_eff_sub          out_sign_big ^ out_sign_small
//   out_class            0 NORMAL, 1 QNAN, 2 INF, 3 INVALID, 4 ZERO
//   dbg_state            FSM state (0 IDLE, 1 DEC, 2 CMP, 3 OUT)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid must not depend on ready. Once valid is raised, the
// source holds it and its payload stable until the transfer happens.
module fp_prep_arbiter #(
  parameter int DIFF_W   = 5,
  parameter int DIFF_MAX = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        in_valid,
  output logic [1:0]        in_ready,
  input  logic [31:0]       in_a0,
  input  logic [31:0]       in_b0,
  input  logic [31:0]       in_a1,
  input  logic [31:0]       in_b1,
  input  logic [1:0]        in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_id,
  output logic              out_sign_big,
  output logic              out_sign_small,
  output logic [7:0]        out_exp_big,
  output logic [23:0]       out_mant_big,
  output logic [23:0]       out_mant_small,
  output logic [DIFF_W-1:0] out_diff,
  output logic              out_swap,
  output logic              out_eff_sub,
  output logic [2:0]        out_class,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_CMP  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [2:0] CLS_NORMAL  = 3'd0;
  localparam logic [2:0] CLS_QNAN    = 3'd1;
  localparam logic [2:0] CLS_INF     = 3'd2;
  localparam logic [2:0] CLS_INVALID = 3'd3;
  localparam logic [2:0] CLS_ZERO    = 3'd4;

  state_t state;
  logic   last_id;   // requester served most recently

  // Operands latched at accept
  logic [31:0] a_q, b_q;
  logic        sub_q, id_q;

  // Decoded operands, registered at DEC
  logic        d_sign_a, d_sign_b;
  logic [7:0]  d_exp_a, d_exp_b;     // effective exponents
  logic [23:0] d_mant_a, d_mant_b;
  logic [30:0] d_mag_a, d_mag_b;     // {exp,frac} magnitude keys
  logic        d_nan_a, d_nan_b, d_inf_a, d_inf_b, d_zero_a, d_zero_b;

  assign dbg_state = state;

  // ---------------- arbitration ----------------
  // When both requesters are valid, the one not served last wins.
  logic grant, accept;

  always_comb begin
    grant = in_valid[1];
    if (in_valid == 2'b11) grant = ~last_id;
    in_ready = 2'b00;
    if (state == S_IDLE) in_ready[grant] = 1'b1;
    accept = |(in_valid & in_ready);
  end

  // ---------------- decode ----------------
  logic [7:0]  exp_a_raw, exp_b_raw;
  logic [22:0] frac_a, frac_b;

  always_comb begin
    exp_a_raw = a_q[30:23];
    exp_b_raw = b_q[30:23];
`ifdef FP_PREP_FTZ_EN
    // A denormal has a zero exponent field, so clearing its fraction
    // turns it into a signed zero.
    frac_a = (exp_a_raw == 8'd0) ? 23'd0 : a_q[22:0];
    frac_b = (exp_b_raw == 8'd0) ? 23'd0 : b_q[22:0];
`else
    frac_a = a_q[22:0];
    frac_b = b_q[22:0];
`endif
  end

  // ---------------- compare / classify ----------------
  logic        c_swap, c_sign_big, c_sign_small, c_eff_sub;
  logic [7:0]  c_exp_big, c_exp_small;
  logic [23:0] c_mant_big, c_mant_small;
  logic [8:0]  c_exp_diff;
  logic [DIFF_W-1:0] c_diff;
  logic [2:0]  c_class;

  always_comb begin
    // Equal magnitudes keep the original order.
    c_swap       = (d_mag_b > d_mag_a);
    c_sign_big   = c_swap ? d_sign_b : d_sign_a;
    c_sign_small = c_swap ? d_sign_a : d_sign_b;
    c_exp_big    = c_swap ? d_exp_b  : d_exp_a;
    c_exp_small  = c_swap ? d_exp_a  : d_exp_b;
    c_mant_big   = c_swap ? d_mant_b : d_mant_a;
    c_mant_small = c_swap ? d_mant_a : d_mant_b;
    c_eff_sub    = c_sign_big ^ c_sign_small;
    // The larger magnitude never has the smaller effective exponent.
    // A 9-bit difference therefore cannot wrap.
    c_exp_diff   = {1'b0, c_exp_big} - {1'b0, c_exp_small};
    if (c_exp_diff > 9'(DIFF_MAX)) c_diff = DIFF_W'(DIFF_MAX);
    else                           c_diff = c_exp_diff[DIFF_W-1:0];

    if (d_nan_a || d_nan_b)                     c_class = CLS_QNAN;
    else if (d_inf_a && d_inf_b && c_eff_sub)   c_class = CLS_INVALID;
    else if (d_inf_a || d_inf_b)                c_class = CLS_INF;
    else if (d_zero_a && d_zero_b)              c_class = CLS_ZERO;
    else                                        c_class = CLS_NORMAL;
  end

  // ---------------- FSM and registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      last_id        <= 1'b1;     // first contested grant goes to requester 0
      a_q            <= '0;
      b_q            <= '0;
      sub_q          <= 1'b0;
      id_q           <= 1'b0;
      d_sign_a       <= 1'b0;
      d_sign_b       <= 1'b0;
      d_exp_a        <= '0;
      d_exp_b        <= '0;
      d_mant_a       <= '0;
      d_mant_b       <= '0;
      d_mag_a        <= '0;
      d_mag_b        <= '0;
      d_nan_a        <= 1'b0;
      d_nan_b        <= 1'b0;
      d_inf_a        <= 1'b0;
      d_inf_b        <= 1'b0;
      d_zero_a       <= 1'b0;
      d_zero_b       <= 1'b0;
      out_valid      <= 1'b0;
      out_id         <= 1'b0;
      out_sign_big   <= 1'b0;
      out_sign_small <= 1'b0;
      out_exp_big    <= '0;
      out_mant_big   <= '0;
      out_mant_small <= '0;
      out_diff       <= '0;
      out_swap       <= 1'b0;
      out_eff_sub    <= 1'b0;
      out_class      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q   <= grant ? in_a1 : in_a0;
            b_q   <= grant ? in_b1 : in_b0;
            sub_q <= in_sub[grant];
            id_q  <= grant;
            state <= S_DEC;
          end
        end
        S_DEC: begin
          d_sign_a <= a_q[31];
          d_sign_b <= b_q[31] ^ sub_q;
          d_exp_a  <= (exp_a_raw == 8'd0) ? 8'd1 : exp_a_raw;
          d_exp_b  <= (exp_b_raw == 8'd0) ? 8'd1 : exp_b_raw;
          d_mant_a <= {(exp_a_raw != 8'd0), frac_a};
          d_mant_b <= {(exp_b_raw != 8'd0), frac_b};
          d_mag_a  <= {exp_a_raw, frac_a};
          d_mag_b  <= {exp_b_raw, frac_b};
          d_nan_a  <= (exp_a_raw == 8'hFF) && (frac_a != 23'd0);
          d_nan_b  <= (exp_b_raw == 8'hFF) && (frac_b != 23'd0);
          d_inf_a  <= (exp_a_raw == 8'hFF) && (frac_a == 23'd0);
          d_inf_b  <= (exp_b_raw == 8'hFF) && (frac_b == 23'd0);
          d_zero_a <= (exp_a_raw == 8'd0)  && (frac_a == 23'd0);
          d_zero_b <= (exp_b_raw == 8'd0)  && (frac_b == 23'd0);
          state    <= S_CMP;
        end
        S_CMP: begin
          out_valid      <= 1'b1;
          out_id         <= id_q;
          out_sign_big   <= c_sign_big;
          out_sign_small <= c_sign_small;
          out_exp_big    <= c_exp_big;
          out_mant_big   <= c_mant_big;
          out_mant_small <= c_mant_small;
          out_diff       <= c_diff;
          out_swap       <= c_swap;
          out_eff_sub    <= c_eff_sub;
          out_class      <= c_class;
          state          <= S_OUT;
        end
        S_OUT: begin
          // All out_* fields stay frozen until the adder takes the result.
          if (out_ready) begin
            out_valid <= 1'b0;
            last_id   <= out_id;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_prep_arbiter.sv
module tb_fp_prep_arbiter;

  localparam int W = 69;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [31:0] in_a0, in_b0, in_a1, in_b1;
  logic [1:0]  in_sub;
  logic        out_valid, out_ready, out_id;
  logic        out_sign_big, out_sign_small, out_swap, out_eff_sub;
  logic [7:0]  out_exp_big;
  logic [23:0] out_mant_big, out_mant_small;
  logic [4:0]  out_diff;
  logic [2:0]  out_class;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  wire [W-1:0] got = {out_id, out_sign_big, out_sign_small, out_exp_big, out_mant_big,
                      out_mant_small, out_diff, out_swap, out_eff_sub, out_class};

  fp_prep_arbiter #(.DIFF_W(5), .DIFF_MAX(27)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a0(in_a0), .in_b0(in_b0), .in_a1(in_a1), .in_b1(in_b1), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_sign_big(out_sign_big), .out_sign_small(out_sign_small),
    .out_exp_big(out_exp_big), .out_mant_big(out_mant_big), .out_mant_small(out_mant_small),
    .out_diff(out_diff), .out_swap(out_swap), .out_eff_sub(out_eff_sub),
    .out_class(out_class), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input bit id, input logic [31:0] a, input logic [31:0] b,
                                         input bit sub);
    int ea, eb, fa, fb, xa, xb, ma, mb, maga, magb, d, cls;
    bit sa, sb, sw, sbig, ssml, esub, na, nb, ia, ib, za, zb;
    int ebig, mbig, msml;
    sa = a[31]; sb = b[31] ^ sub;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = int'(a[22:0]);  fb = int'(b[22:0]);
`ifdef FP_PREP_FTZ_EN
    if (ea == 0) fa = 0;
    if (eb == 0) fb = 0;
`endif
    na = (ea == 255) && (fa != 0); nb = (eb == 255) && (fb != 0);
    ia = (ea == 255) && (fa == 0); ib = (eb == 255) && (fb == 0);
    za = (ea == 0) && (fa == 0);   zb = (eb == 0) && (fb == 0);
    xa = (ea == 0) ? 1 : ea;       xb = (eb == 0) ? 1 : eb;
    ma = ((ea != 0) ? 8388608 : 0) + fa;
    mb = ((eb != 0) ? 8388608 : 0) + fb;
    maga = ea * 8388608 + fa;      magb = eb * 8388608 + fb;
    sw = magb > maga;
    if (sw) begin sbig = sb; ssml = sa; ebig = xb; mbig = mb; msml = ma; d = xb - xa; end
    else    begin sbig = sa; ssml = sb; ebig = xa; mbig = ma; msml = mb; d = xa - xb; end
    if (d > 27) d = 27;
    esub = sbig ^ ssml;
    if (na || nb)               cls = 1;
    else if (ia && ib && esub)  cls = 3;
    else if (ia || ib)          cls = 2;
    else if (za && zb)          cls = 4;
    else                        cls = 0;
    return {id, sbig, ssml, 8'(ebig), 24'(mbig), 24'(msml), 5'(d), sw, esub, 3'(cls)};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       v = {s, 31'd0};
      1:       v = {s, 8'hFF, 23'd0};
      2:       v = {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      3:       v = {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
      4:       v = {s, 8'($urandom_range(1, 254)), 23'($urandom_range(0, 23'h7FFFFF))};
      default: v = {s, 8'($urandom_range(120, 135)), 23'($urandom_range(0, 23'h7FFFFF))};
    endcase
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge; a result seen valid & ready here transfers on the next rise.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got=%h required=no output", got);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL sb_result got=%h required=%h", got, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All input changes happen 1 time unit after a rising edge.
  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b, input bit sub);
    int n;
    if (id) begin in_a1 = a; in_b1 = b; end
    else    begin in_a0 = a; in_b0 = b; end
    in_sub[id] = sub;
    in_valid[id] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready[id] && n < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready[id]) begin
      errors++;
      $display("FAIL accept_timeout id=%0d got=no ready required=ready", id);
    end else begin
      exp_q.push_back(model(id, a, b, sub));
    end
    @(posedge clk); #1;
    in_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_out_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL %s_valid_timeout got=0 required=1", tag);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 2'b00; in_sub = 2'b00; out_ready = 1'b0;
    in_a0 = '0; in_b0 = '0; in_a1 = '0; in_b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || got !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b/%h required=0/0", out_valid, got);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d required=0", dbg_state);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    out_ready = 1'b0;
    // 3.0 + 1.0 from requester 0; checks latency and each field
    send(1'b0, 32'h40400000, 32'h3F800000, 1'b0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_dec got=%b required=0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_cmp got=%b required=0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_out got=%b required=1", out_valid); end
    checks++;
    if (out_exp_big !== 8'h80 || out_mant_big !== 24'hC00000 || out_mant_small !== 24'h800000 ||
        out_diff !== 5'd1 || out_swap !== 1'b0 || out_eff_sub !== 1'b0 || out_class !== 3'd0 ||
        out_id !== 1'b0) begin
      errors++;
      $display("FAIL basic_add got=%h required=exp80 mbC00000 ms800000 d1 sw0 es0 c0 id0", got);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    out_ready = 1'b0;
    // 1.0 - 3.0 from requester 1
    send(1'b1, 32'h3F800000, 32'h40400000, 1'b1);
    wait_out_valid("basic_sub");
    checks++;
    if (out_swap !== 1'b1 || out_sign_big !== 1'b1 || out_sign_small !== 1'b0 ||
        out_eff_sub !== 1'b1 || out_diff !== 5'd1 || out_id !== 1'b1) begin
      errors++;
      $display("FAIL basic_sub got=%h required=sw1 sb1 ss0 es1 d1 id1", got);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_specials();
    logic [31:0] ta[5];
    logic [31:0] tb[5];
    logic        ts[5];
    logic [2:0]  tc[5];
    ta[0] = 32'h7FC00000; tb[0] = 32'h3F800000; ts[0] = 1'b0; tc[0] = 3'd1;
    ta[1] = 32'h7F800000; tb[1] = 32'h7F800000; ts[1] = 1'b1; tc[1] = 3'd3;
    ta[2] = 32'h7F800000; tb[2] = 32'h7F800000; ts[2] = 1'b0; tc[2] = 3'd2;
    ta[3] = 32'h80000000; tb[3] = 32'h00000000; ts[3] = 1'b0; tc[3] = 3'd4;
    ta[4] = 32'h00000001; tb[4] = 32'h3F800000; ts[4] = 1'b0; tc[4] = 3'd0;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      send(1'(i % 2), ta[i], tb[i], ts[i]);
      wait_out_valid("special");
      checks++;
      if (out_class !== tc[i]) begin
        errors++;
        $display("FAIL special_class case=%0d got=%0d required=%0d", i, out_class, tc[i]);
      end
      if (i == 4) begin
        // tiny denormal against 1.0: shift clamps at 27
        checks++;
`ifdef FP_PREP_FTZ_EN
        if (out_mant_small !== 24'h000000 || out_diff !== 5'd27) begin
`else
        if (out_mant_small !== 24'h000001 || out_diff !== 5'd27) begin
`endif
          errors++;
          $display("FAIL denorm_clamp got=ms%h d%0d required=d27", out_mant_small, out_diff);
        end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();
    end
  endtask

  task automatic test_back_to_back();
    bit ids[$];
    int n;
    test_reset();
    out_ready = 1'b1;
    in_a0 = rand_fp(); in_b0 = rand_fp(); in_a1 = rand_fp(); in_b1 = rand_fp();
    in_sub = 2'($urandom_range(0, 3));
    in_valid = 2'b11;
    n = 0;
    while (ids.size() < 4 && n < 100) begin
      @(negedge clk);
      if (in_ready[0] || in_ready[1]) begin
        bit g;
        g = in_ready[1];
        exp_q.push_back(model(g, g ? in_a1 : in_a0, g ? in_b1 : in_b0, in_sub[g]));
        ids.push_back(g);
        @(posedge clk); #1;
        if (g) begin in_a1 = rand_fp(); in_b1 = rand_fp(); end
        else   begin in_a0 = rand_fp(); in_b0 = rand_fp(); end
        in_sub[g] = 1'($urandom_range(0, 1));
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    in_valid = 2'b00;
    checks++;
    if (ids.size() != 4 || ids[0] !== 1'b0 || ids[1] !== 1'b1 || ids[2] !== 1'b0 || ids[3] !== 1'b1) begin
      errors++;
      $display("FAIL rr_order got=%p required=0,1,0,1", ids);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] snap;
    out_ready = 1'b0;
    send(1'b0, 32'hC1200000, 32'h3E800000, 1'b1);
    wait_out_valid("hold");
    snap = got;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || got !== snap) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d got=%b/%h required=1/%h", i, out_valid, got, snap);
      end
    end
    checks++;
    if (in_ready !== 2'b00) begin
      errors++;
      $display("FAIL hold_no_accept got=%b required=00", in_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_in_cmp();
    out_ready = 1'b1;
    in_a0 = 32'h40400000; in_b0 = 32'h3F800000; in_sub[0] = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL rst_cmp_reach got=%0d required=2", dbg_state);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL rst_cmp_async got=%b/%0d required=0/0", out_valid, dbg_state);
    end
    #1;
    rst_n = 1'b1;
    in_a0 = 32'hBF000000; in_b0 = 32'h3F000000; in_sub[0] = 1'b1;
    in_valid[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_cmp_recover got=v%b r%b required=v0 r1", out_valid, in_ready[0]);
    end else begin
      exp_q.push_back(model(1'b0, in_a0, in_b0, 1'b1));
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 1)), rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_back_to_back();
    test_backpressure();
    test_reset_in_cmp();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
